// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave register file.
//   state_t        - frame state machine encoding
//   ADDR_MAP       - command addresses mapped to register entries 0..7
//   DEFAULT_TABLE  - reset contents, entry 0 in bits [63:56]
//   CMD_WR_BIT     - command byte bit selecting write (1) or read (0)
//   decode_addr()  - address lookup returning mapped flag and entry index
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam int unsigned NUM_ENTRIES = 8;
    localparam int unsigned CMD_WR_BIT  = 7;

    localparam logic [6:0] ADDR_MAP [NUM_ENTRIES] = '{
        7'h1A, 7'h1B, 7'h1C, 7'h1D, 7'h2A, 7'h2B, 7'h2C, 7'h2D
    };

    localparam logic [63:0] DEFAULT_TABLE = 64'h41DC3B4E8CB505E5;

    typedef struct packed {
        logic       mapped;
        logic [2:0] idx;
    } decode_t;

    function automatic decode_t decode_addr(input logic [6:0] addr);
        decode_t d;
        d = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (addr == ADDR_MAP[i]) begin
                d.mapped = 1'b1;
                d.idx    = 3'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with single-cycle edge detect.
//   clk, rst_n - system clock, asynchronous active-low reset
//   d          - asynchronous input pin
//   q          - synchronized level
//   rise, fall - one-clk pulses on synchronized rising/falling edges
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: CLK-oversampled SPI mode-0 slave with an 8x8 register file.
//   CLK, RST_N - system clock, asynchronous active-low reset
//   SCLK, MOSI, SS - SPI pins from the master (asynchronous to CLK)
//   MISO       - slave data out, 0 while not selected
//   WR_STROBE  - one-CLK pulse on a committed register write
//   WR_ADDR    - entry index of the last committed write
//   BUSY       - frame in progress
// Frame: command byte (bit 7 = write, bits [6:0] = address), then data byte.
// The data byte returns the addressed entry's current value on MISO.
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter logic        SS_ACTIVE_HIGH = 1'b1,
    parameter logic [63:0] RESET_TABLE    = DEFAULT_TABLE
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       SS,
    output logic       MISO,
    output logic       WR_STROBE,
    output logic [2:0] WR_ADDR,
    output logic       BUSY
);

    // Reset asserts immediately, releases on CLK.
    logic rst_meta;
    logic rst_n_int;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_meta  <= 1'b0;
            rst_n_int <= 1'b0;
        end else begin
            rst_meta  <= 1'b1;
            rst_n_int <= rst_meta;
        end
    end

    logic sclk_q, sclk_rise, sclk_fall;
    logic ss_q, ss_rise, ss_fall;
    logic mosi_q, mosi_rise, mosi_fall;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk  (CLK),
        .rst_n(rst_n_int),
        .d    (SCLK),
        .q    (sclk_q),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(!SS_ACTIVE_HIGH)) u_sync_ss (
        .clk  (CLK),
        .rst_n(rst_n_int),
        .d    (SS),
        .q    (ss_q),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk  (CLK),
        .rst_n(rst_n_int),
        .d    (MOSI),
        .q    (mosi_q),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    logic sel;
    logic ss_assert;
    logic sclk_level_unused;
    logic mosi_edges_unused;

    assign sel               = SS_ACTIVE_HIGH ? ss_q : ~ss_q;
    assign ss_assert         = SS_ACTIVE_HIGH ? ss_rise : ss_fall;
    assign sclk_level_unused = sclk_q;
    assign mosi_edges_unused = mosi_rise | mosi_fall;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sr;
    logic [7:0] tx_sr;
    logic       wr_q;
    logic       mapped_q;
    logic [2:0] idx_q;
    logic [7:0] regs [NUM_ENTRIES];
    logic       miso_q;

    logic       byte_done;
    logic [7:0] rx_next;
    decode_t    dec;
    logic       commit;

    always_comb begin
        byte_done = sel && sclk_rise && (bit_cnt == 3'd7);
        rx_next   = {rx_sr[6:0], mosi_q};
        dec       = decode_addr(rx_next[6:0]);
        commit    = (state_q == ST_DATA) && byte_done && wr_q && mapped_q;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (ss_assert) state_d = ST_CMD;
            ST_CMD:  if (byte_done) state_d = ST_DATA;
            ST_DATA: if (byte_done) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
        endcase
        // Deselect overrides everything, including an edge in the same cycle.
        if (!sel) state_d = ST_IDLE;
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            wr_q      <= 1'b0;
            mapped_q  <= 1'b0;
            idx_q     <= '0;
            miso_q    <= 1'b0;
            WR_STROBE <= 1'b0;
            WR_ADDR   <= '0;
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                regs[i] <= RESET_TABLE[63 - 8*i -: 8];
            end
        end else begin
            WR_STROBE <= commit;
            if (commit) begin
                regs[idx_q] <= rx_next;
                WR_ADDR     <= idx_q;
            end

            if (!sel) begin
                bit_cnt <= '0;
                miso_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        bit_cnt <= '0;
                        miso_q  <= 1'b0;
                    end
                    ST_CMD: begin
                        miso_q <= 1'b0;
                        if (sclk_rise) begin
                            rx_sr   <= rx_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                wr_q     <= rx_next[CMD_WR_BIT];
                                mapped_q <= dec.mapped;
                                idx_q    <= dec.idx;
                                tx_sr    <= dec.mapped ? regs[dec.idx] : 8'h00;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sclk_rise) begin
                            rx_sr   <= rx_next;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (sclk_fall) begin
                            miso_q <= tx_sr[7];
                            tx_sr  <= {tx_sr[6:0], 1'b0};
                        end
                    end
                    ST_DONE: begin
                        miso_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign MISO = miso_q;
    assign BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_regfile.sv
module tb_spi_slave_regfile;

    localparam int NI   = 4;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       mosi;
    logic [NI-1:0] ss_bus;
    logic [NI-1:0] miso_bus;
    logic [NI-1:0] strobe;
    logic [NI-1:0] busy;
    logic [2:0] wr_addr [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_slave_regfile #(
            .SS_ACTIVE_HIGH(1'b1),
            .RESET_TABLE   (64'h41DC3B4E8CB505E5)
        ) u_dut (
            .CLK      (clk),
            .RST_N    (rst_n),
            .SCLK     (sclk),
            .MOSI     (mosi),
            .SS       (ss_bus[g]),
            .MISO     (miso_bus[g]),
            .WR_STROBE(strobe[g]),
            .WR_ADDR  (wr_addr[g]),
            .BUSY     (busy[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: per-instance register arrays and the address table.
    int unsigned amap [8] = '{'h1A, 'h1B, 'h1C, 'h1D, 'h2A, 'h2B, 'h2C, 'h2D};
    logic [7:0] rtab [8] = '{8'h41, 8'hDC, 8'h3B, 8'h4E, 8'h8C, 8'hB5, 8'h05, 8'hE5};
    logic [7:0] model [NI][8];

    function automatic int lookup(input logic [6:0] a);
        for (int i = 0; i < 8; i++) if (int'(a) == amap[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++)
            for (int e = 0; e < 8; e++) model[i][e] = rtab[e];
    endtask

    // Monitors: strobe high-cycle count, last strobed address, stray MISO.
    int         strobe_cnt [NI];
    logic [2:0] last_addr  [NI];
    int         quiet_err = 0;
    int         cur_inst  = -1;

    initial for (int i = 0; i < NI; i++) begin strobe_cnt[i] = 0; last_addr[i] = '0; end

    always @(negedge clk) begin
        for (int j = 0; j < NI; j++) begin
            if (strobe[j] === 1'b1) begin
                strobe_cnt[j]++;
                last_addr[j] = wr_addr[j];
            end
            if (j != cur_inst && miso_bus[j] !== 1'b0) quiet_err++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI frame as master; nbits < 16 aborts early, rst_bit >= 0 resets mid-frame.
    task automatic frame(input int inst, input logic [7:0] cmd, input logic [7:0] wdata,
                         input int nbits, input int rst_bit,
                         output logic [7:0] rdata, output logic busy_after);
        logic [15:0] word;
        word  = {cmd, wdata};
        rdata = '0;
        cur_inst = inst;
        ss_bus = NI'(1) << inst;
        idle(HALF);
        for (int b = 0; b < nbits; b++) begin
            if (b == rst_bit) begin
                rst_n = 1'b0;
                idle(2);
                check("rst_miso", 32'(miso_bus[inst]), 32'd0);
                check("rst_busy", 32'(busy[inst]), 32'd0);
                break;
            end
            mosi = word[15 - b];
            idle(HALF);
            if (b >= 8) rdata = {rdata[6:0], |miso_bus};
            sclk = 1'b1;
            idle(HALF);
            sclk = 1'b0;
        end
        idle(HALF);
        ss_bus = '0;
        idle(4);
        busy_after = busy[inst];
        if (rst_n == 1'b0) rst_n = 1'b1;
        idle(HALF);
        cur_inst = -1;
    endtask

    // Full frame checked against the model.
    task automatic xfer(input int inst, input logic [7:0] cmd, input logic [7:0] wdata);
        int         idx;
        int         s0, q0;
        logic [7:0] exp_rd, rd;
        logic       bz, exp_commit;
        idx    = lookup(cmd[6:0]);
        exp_rd = (idx >= 0) ? model[inst][idx] : 8'h00;
        exp_commit = cmd[7] && (idx >= 0);
        s0 = strobe_cnt[inst];
        q0 = quiet_err;
        frame(inst, cmd, wdata, 16, -1, rd, bz);
        check($sformatf("rd i%0d c%02h", inst, cmd), 32'(rd), 32'(exp_rd));
        check($sformatf("strobe i%0d c%02h", inst, cmd), 32'(strobe_cnt[inst] - s0), 32'(exp_commit));
        check("quiet", 32'(quiet_err - q0), 32'd0);
        check("busy_end", 32'(bz), 32'd0);
        if (exp_commit) begin
            model[inst][idx] = wdata;
            check($sformatf("wr_addr i%0d", inst), 32'(last_addr[inst]), 32'(idx));
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       bz;
        int         s0;
        logic [6:0] ua;

        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss_bus = '0;
        model_reset();
        idle(5);
        rst_n = 1'b1;
        idle(5);

        for (int i = 0; i < NI; i++) begin
            check("reset_miso", 32'(miso_bus[i]), 32'd0);
            check("reset_busy", 32'(busy[i]), 32'd0);
            check("reset_strobe", 32'(strobe[i]), 32'd0);
            check("reset_wr_addr", 32'(wr_addr[i]), 32'd0);
        end

        // Reset table readback.
        for (int e = 0; e < 8; e++) xfer(0, 8'(amap[e]), 8'h00);

        // Write 9C/77 then read 1C.
        xfer(0, 8'h9C, 8'h77);
        xfer(0, 8'h1C, 8'h00);
        check("w9c_model", 32'(model[0][2]), 32'h77);

        // Unmapped read and write.
        xfer(0, 8'h3F, 8'h12);
        xfer(0, 8'hBF, 8'h55);

        // Aborted write to 2D after 12 bits.
        s0 = strobe_cnt[0];
        frame(0, 8'hAD, 8'hAA, 12, -1, rd, bz);
        check("abort_busy", 32'(bz), 32'd0);
        check("abort_strobe", 32'(strobe_cnt[0] - s0), 32'd0);
        xfer(0, 8'h2D, 8'h00);

        // Instance 2 on the one-hot bus.
        xfer(2, 8'h2B, 8'h00);

        // Reset mid-data-byte after writing 1A=00.
        xfer(0, 8'h9A, 8'h00);
        frame(0, 8'h1A, 8'h00, 16, 12, rd, bz);
        model_reset();
        idle(4);
        check("post_rst_busy", 32'(busy[0]), 32'd0);
        xfer(0, 8'h1A, 8'h00);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int inst;
            logic [7:0] cmd;
            inst = int'($urandom_range(0, NI - 1));
            if ($urandom_range(0, 3) != 0) begin
                cmd[6:0] = 7'(amap[$urandom_range(0, 7)]);
            end else begin
                ua = 7'($urandom);
                while (lookup(ua) >= 0) ua = 7'($urandom);
                cmd[6:0] = ua;
            end
            cmd[7] = 1'($urandom_range(0, 1));
            xfer(inst, cmd, 8'($urandom));
        end

        // Final sweep of all entries on all instances.
        for (int i = 0; i < NI; i++)
            for (int e = 0; e < 8; e++) xfer(i, 8'(amap[e]), 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_regfile.md
# spi_slave_regfile

System-clocked SPI slave responder holding an 8-entry byte register file that the existing SPI master reads (and now writes) over SCLK/MOSI/MISO/SS. It oversamples the SPI pins on its own clock, decodes a one-byte command/address, and returns or updates the addressed register during the second byte. One instance sits on each bit of the master's SS bus; MISO outputs are wired-OR at the top level.

## Interface
- SS_ACTIVE_HIGH, 1, select polarity of SS (1: selected when SS=1)
- RESET_TABLE, 64'h41DC3B4E8CB505E5, reset contents of entries 0..7, entry 0 in bits [63:56]
- CLK  input  1  system clock; the only clock in the block
- RST_N  input  1  asynchronous active-low reset
- SCLK  input  1  SPI clock from master, asynchronous to CLK
- MOSI  input  1  master-out data, MSB first
- SS  input  1  slave select from master's SS bus
- MISO  output  1  slave-out data; 0 whenever not selected (wired-OR safe)
- WR_STROBE  output  1  one-CLK pulse when a register write commits
- WR_ADDR  output  3  entry index of the last committed write
- BUSY  output  1  1 while a frame is in progress (state ≠ IDLE)

## Operation
- SPI mode 0: MOSI sampled on SCLK rising edge; MISO updated on SCLK falling edge; MSB first.
- Address map (bits [6:0] of command byte): 1A,1B,1C,1D,2A,2B,2C,2D -> entries 0..7; any other value is unmapped.
- Command byte bit 7: 0 = read, 1 = write (so 9A writes entry 0).
- States: IDLE, CMD, DATA, DONE.
  - IDLE -> CMD on SS assert.
  - CMD: shift 8 MOSI bits; after 8th rising edge, decode and load TX shift register with addressed entry (00 if unmapped) -> DATA.
  - DATA: shift out TX byte on MISO, shift in 8 MOSI bits; after 8th rising edge: if write and mapped, commit RX byte to entry, pulse WR_STROBE, update WR_ADDR -> DONE.
  - DONE: MISO=0, ignore further SCLK edges until SS deassert.
  - Any state -> IDLE on SS deassert; no commit, bit counter cleared.
- Write frames also return the pre-write value on MISO during the data byte.
- Unmapped write: no commit, no WR_STROBE.
- Reset values: MISO=0, WR_STROBE=0, WR_ADDR=0, BUSY=0, state IDLE, bit counter 0, entries = RESET_TABLE.

## Timing
- SCLK, MOSI, SS each pass a 2-flop synchronizer; SCLK edges detected one CLK later (3 CLK pin-to-event).
- Requirement on master: SCLK high and low phases each ≥ 4 CLK; SS assert ≥ 4 CLK before first SCLK rising edge.
- Decode/TX load: 1 CLK after 8th detected rising edge; TX bit 7 drives MISO on the following SCLK falling edge detection, then one bit per falling edge.
- Commit: WR_STROBE high exactly 1 CLK, the CLK after 16th detected rising edge; new value readable in next frame.
- SS deassert: MISO forced 0 and BUSY cleared within 1 CLK of synchronized deassert.
- Same-CLK SS deassert and SCLK edge: deselect wins, edge ignored.
- RST_N assert mid-frame: all state and entries return to reset values immediately; deassert synchronized to CLK internally.

## Structure
- Package spi_pkg: state enum, address-map constants (8 mapped addresses), default table constant, command bit index.
- Sub-module spi_sync_edge: 2-flop synchronizer plus rise/fall detect; instantiated for SCLK and SS; MOSI uses its synchronizer output only.
- Top holds FSM, 3-bit bit counter, RX/TX shift registers, 8x8 register file.

## Test plan
- After reset, read 1A,1B,...,2D -> returns 41,DC,3B,4E,8C,B5,05,E5; WR_STROBE never pulses.
- Write 9C with data 77, then read 1C -> write frame returns 3B, WR_STROBE pulses once with WR_ADDR=2, read returns 77.
- Read 3F and write BF/55 -> both return 00, no WR_STROBE, table unchanged.
- Write 2D/AA with SS dropped after 12 bits, then read 2D -> returns E5, BUSY low within 4 CLK of SS drop.
- Four instances on a one-hot SS bus, read 2B from instance 2 -> MISO of instances 0,1,3 stays 0 throughout; combined MISO yields B5.
- Assert RST_N mid-data-byte after writing 1A=00 -> entry 0 reads 41 afterward, MISO=0 during reset.
